// File: rtl/tx_frame_scheduler_pkg.sv
// tx_frame_scheduler shared types and constants.
// TX_FRAME_CHECKSUM_EN selects the 8-byte frame with trailing XOR byte.
package tx_frame_scheduler_pkg;

  localparam logic [7:0] HEADER_DEF = 8'hAA;
  localparam int DROP_CNT_W_DEF = 8;

  localparam int FRAME_LEN_CHK = 8;
  localparam int FRAME_LEN_NOCHK = 7;

`ifdef TX_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int FRAME_LEN = FRAME_LEN_NOCHK;
`endif

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [15:0] max_a;
    logic [15:0] min_a;
    logic [15:0] obs;
  } result_t;

  function automatic logic [7:0] chk_xor(
    input result_t r
  );
    return r.max_a[15:8] ^ r.max_a[7:0]
         ^ r.min_a[15:8] ^ r.min_a[7:0]
         ^ r.obs[15:8]   ^ r.obs[7:0];
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Result strobe plus byte transmitter handshake.
// master drives results/busy, slave is the scheduler.
interface tx_frame_scheduler_if;

  logic        res_valid;
  logic [15:0] max_dist_angle;
  logic [15:0] min_dist_angle;
  logic [15:0] obs_alert;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;

  modport master (
    output res_valid,
    output max_dist_angle,
    output min_dist_angle,
    output obs_alert,
    output tx_busy,
    input  tx_start,
    input  tx_byte
  );

  modport slave (
    input  res_valid,
    input  max_dist_angle,
    input  min_dist_angle,
    input  obs_alert,
    input  tx_busy,
    output tx_start,
    output tx_byte
  );

endinterface

// File: rtl/tx_frame_scheduler_byte_sel.sv
// Frame byte mux: index + snapshot -> byte.
// TX_FRAME_CHECKSUM_EN adds the XOR byte at index 7.
module tx_frame_scheduler_byte_sel
  import tx_frame_scheduler_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  result_t    i_snap,
  input  logic [2:0] i_idx,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = 8'h00;
    case (i_idx)
      3'd0: o_byte = HEADER;
      3'd1: o_byte = i_snap.max_a[15:8];
      3'd2: o_byte = i_snap.max_a[7:0];
      3'd3: o_byte = i_snap.min_a[15:8];
      3'd4: o_byte = i_snap.min_a[7:0];
      3'd5: o_byte = i_snap.obs[15:8];
      3'd6: o_byte = i_snap.obs[7:0];
`ifdef TX_FRAME_CHECKSUM_EN
      3'd7: o_byte = chk_xor(i_snap);
`endif
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Result frame serialiser onto a start/busy byte transmitter.
// Frame length set by TX_FRAME_CHECKSUM_EN (see package).
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  tx_frame_scheduler_if.slave   bus,
  output logic                  o_frame_active,
  output logic [DROP_CNT_W-1:0] o_drop_count
);

  state_e r_state;
  state_e w_state_nxt;

  result_t r_active;
  result_t w_active_nxt;
  result_t r_pend;
  result_t w_pend_nxt;
  result_t w_in;

  logic       r_pend_full;
  logic       w_pend_full_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic       w_frame_end;
  logic       w_drop_inc;

  logic                  r_tx_start;
  logic [7:0]            r_tx_byte;
  logic                  r_frame_active;
  logic [DROP_CNT_W-1:0] r_drop;

  logic       w_tx_start_d;
  logic [7:0] w_tx_byte_d;
  logic       w_frame_active_d;
  logic [7:0] w_sel_byte;

  assign w_in = {bus.max_dist_angle,
                 bus.min_dist_angle,
                 bus.obs_alert};

  // Byte for the next ISSUE, so tx_byte is ready on entry.
  tx_frame_scheduler_byte_sel #(
    .HEADER (HEADER)
  ) u_sel (
    .i_snap (w_active_nxt),
    .i_idx  (w_idx_nxt),
    .o_byte (w_sel_byte)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_active       <= '0;
      r_pend         <= '0;
      r_pend_full    <= 1'b0;
      r_idx          <= 3'd0;
      r_tx_start     <= 1'b0;
      r_tx_byte      <= 8'h00;
      r_frame_active <= 1'b0;
      r_drop         <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_active       <= w_active_nxt;
      r_pend         <= w_pend_nxt;
      r_pend_full    <= w_pend_full_nxt;
      r_idx          <= w_idx_nxt;
      r_tx_start     <= w_tx_start_d;
      r_tx_byte      <= w_tx_byte_d;
      r_frame_active <= w_frame_active_d;
      if (w_drop_inc && (r_drop != '1))
        r_drop <= r_drop + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_pend_nxt      = r_pend;
    w_pend_full_nxt = r_pend_full;
    w_idx_nxt       = r_idx;
    w_frame_end     = 1'b0;
    w_drop_inc      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.res_valid) begin
          w_active_nxt = w_in;
          w_idx_nxt    = 3'd0;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_tx_start)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.tx_busy) begin
          if (r_idx != LAST_IDX) begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_frame_end = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Frame end chains straight into the next frame.
    if (w_frame_end) begin
      w_idx_nxt = 3'd0;
      if (r_pend_full) begin
        w_active_nxt = r_pend;
        w_state_nxt  = S_ISSUE;
        if (bus.res_valid)
          w_pend_nxt = w_in;
        else
          w_pend_full_nxt = 1'b0;
      end else if (bus.res_valid) begin
        w_active_nxt = w_in;
        w_state_nxt  = S_ISSUE;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (bus.res_valid &&
                 (r_state != S_IDLE)) begin
      w_pend_nxt      = w_in;
      w_pend_full_nxt = 1'b1;
      w_drop_inc      = r_pend_full;
    end
  end

  always_comb begin
    w_tx_start_d     = (w_state_nxt == S_ISSUE)
                     && !bus.tx_busy;
    w_tx_byte_d      = r_tx_byte;
    w_frame_active_d = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_ISSUE)
      w_tx_byte_d = w_sel_byte;
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.tx_byte    = r_tx_byte;
  assign o_frame_active = r_frame_active;
  assign o_drop_count   = r_drop;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a 10-cycle
// busy transmitter model; frame length follows TX_FRAME_CHECKSUM_EN.
module tb_tx_frame_scheduler;

  typedef logic [7:0] frm_t [8];

`ifdef TX_FRAME_CHECKSUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_active;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int bcnt = 0;
  int cap_n = 0;
  int fa_low = 0;
  int base;
  int fa0;
  logic [7:0] cap [4096];

  frm_t F1, F2, F3, F4;

  tx_frame_scheduler_if bus();

  tx_frame_scheduler dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus),
    .o_frame_active (frame_active),
    .o_drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  assign bus.tx_busy = (bcnt != 0);

  // Transmitter model and byte capture
  always @(posedge clk) begin
    if (bus.tx_start) begin
      bcnt <= 10;
      cap[cap_n[11:0]] <= bus.tx_byte;
      cap_n <= cap_n + 1;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  always @(negedge clk)
    if (!frame_active) fa_low <= fa_low + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] mx,
                      input logic [15:0] mn,
                      input logic [15:0] ob);
    @(negedge clk);
    bus.res_valid = 1'b1;
    bus.max_dist_angle = mx;
    bus.min_dist_angle = mn;
    bus.obs_alert = ob;
    tick();
    bus.res_valid = 1'b0;
    bus.max_dist_angle = 16'hBEEF;
    bus.min_dist_angle = 16'hCAFE;
    bus.obs_alert = 16'hF00D;
  endtask

  task automatic wait_idle(input string tag,
                           input int lim);
    int k = 0;
    while (frame_active && k < lim) begin
      tick();
      k++;
    end
    chk(tag, 32'(frame_active), 32'd0);
  endtask

  task automatic wait_issue(input string tag,
                            input int b,
                            input int n,
                            input int lim);
    int k = 0;
    while (!(bus.tx_start && cap_n == b + n)
           && k < lim) begin
      tick();
      k++;
    end
    chk(tag, 32'(bus.tx_start), 32'd1);
  endtask

  task automatic chk_frame(input string tag,
                           input frm_t f,
                           input int b);
    for (int i = 0; i < FLEN; i++)
      chk($sformatf("%s[%0d]", tag, i),
          32'(cap[b + i]), 32'(f[i]));
  endtask

  initial begin
    F1 = '{8'hAA, 8'h12, 8'h34, 8'h00,
           8'h56, 8'h00, 8'h01, 8'h71};
    F2 = '{8'hAA, 8'hFF, 8'hFF, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00};
    F3 = '{8'hAA, 8'h01, 8'h02, 8'h03,
           8'h04, 8'h05, 8'h06, 8'h07};
    F4 = '{8'hAA, 8'h80, 8'h01, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h81};
    bus.res_valid = 1'b0;
    bus.max_dist_angle = '0;
    bus.min_dist_angle = '0;
    bus.obs_alert = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
    chk("rst_active", 32'(frame_active), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single frame, first byte one cycle after strobe
    base = cap_n;
    send(16'h1234, 16'h0056, 16'h0001);
    chk("one_start", 32'(bus.tx_start), 32'd1);
    chk("one_hdr", 32'(bus.tx_byte), 32'hAA);
    chk("one_active", 32'(frame_active), 32'd1);
    wait_idle("one_idle", 400);
    chk("one_len", 32'(cap_n - base), 32'(FLEN));
    chk_frame("one", F1, base);
    chk("one_drop", 32'(drop_count), 32'd0);

    // result arriving during byte 3
    base = cap_n;
    send(16'h1234, 16'h0056, 16'h0001);
    wait_issue("mid_b3", base, 3, 200);
    fa0 = fa_low;
    send(16'hFFFF, 16'h0000, 16'h0000);
    wait_idle("mid_idle", 800);
    chk("mid_gap", 32'(fa_low - fa0), 32'd0);
    chk("mid_len", 32'(cap_n - base), 32'(2 * FLEN));
    chk_frame("mid_f1", F1, base);
    chk_frame("mid_f2", F2, base + FLEN);
    chk("mid_drop", 32'(drop_count), 32'd0);

    // strobe on the final busy-low cycle, pending empty
    base = cap_n;
    send(16'h1234, 16'h0056, 16'h0001);
    wait_issue("col_last", base, FLEN - 1, 200);
    repeat (11) @(posedge clk);
    fa0 = fa_low;
    send(16'h8001, 16'h0000, 16'h0000);
    chk("col_start", 32'(bus.tx_start), 32'd1);
    chk("col_hdr", 32'(bus.tx_byte), 32'hAA);
    chk("col_gap", 32'(fa_low - fa0), 32'd0);
    wait_idle("col_idle", 800);
    chk("col_len", 32'(cap_n - base), 32'(2 * FLEN));
    chk_frame("col_f1", F1, base);
    chk_frame("col_f2", F4, base + FLEN);
    chk("col_drop", 32'(drop_count), 32'd0);

    // two strobes mid-frame: second overwrites
    base = cap_n;
    send(16'h1234, 16'h0056, 16'h0001);
    wait_issue("ovf_b2", base, 2, 200);
    send(16'hDEAD, 16'hBEEF, 16'h0000);
    send(16'h0102, 16'h0304, 16'h0506);
    chk("ovf_drop", 32'(drop_count), 32'd1);
    wait_idle("ovf_idle", 800);
    chk("ovf_len", 32'(cap_n - base), 32'(2 * FLEN));
    chk_frame("ovf_f1", F1, base);
    chk_frame("ovf_f2", F3, base + FLEN);

    // continuous strobes saturate the drop counter
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.res_valid = 1'b1;
      bus.max_dist_angle = 16'(i);
    end
    @(negedge clk);
    bus.res_valid = 1'b0;
    tick();
    chk("sat_drop", 32'(drop_count), 32'hFF);
    wait_idle("sat_idle", 2000);
    chk("sat_hold", 32'(drop_count), 32'hFF);

    // reset while byte 4 is on the wire
    base = cap_n;
    send(16'h1234, 16'h0056, 16'h0001);
    wait_issue("rst_b4", base, 4, 200);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_start", 32'(bus.tx_start), 32'd0);
    chk("mrst_active", 32'(frame_active), 32'd0);
    chk("mrst_drop", 32'(drop_count), 32'd0);
    chk("mrst_byte", 32'(bus.tx_byte), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // transmitter still busy: header waits in ISSUE
    base = cap_n;
    send(16'h1234, 16'h0056, 16'h0001);
    chk("hold_start", 32'(bus.tx_start), 32'd0);
    chk("hold_byte", 32'(bus.tx_byte), 32'hAA);
    chk("hold_active", 32'(frame_active), 32'd1);
    wait_idle("post_idle", 400);
    chk("post_len", 32'(cap_n - base), 32'(FLEN));
    chk_frame("post", F1, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
